regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NUM_REQUESTERS, default 4: number of write requesters, range 2..8.
REQ-002 Parameter NUMBER_OF_REGISTERS, default 256: register count; AW = $clog2(NUMBER_OF_REGISTERS); IW = $clog2(NUM_REQUESTERS).
REQ-003 clock_in  input  1  sole clock, all state on rising edge.
REQ-004 reset_n_in  input  1  asynchronous, active-low reset.
REQ-005 req_valid_in  input  NUM_REQUESTERS  bit i: requester i has a write pending.
REQ-006 req_address_in  input  NUM_REQUESTERS*AW  packed; slice i = target register of requester i.
REQ-007 req_data_in  input  NUM_REQUESTERS*8  packed; slice i = write data of requester i.
REQ-008 req_lock_in  input  NUM_REQUESTERS  bit i: requester i requests burst lock; port exists only with REGFILE_ARB_LOCK_EN.
REQ-009 req_ready_out  output  NUM_REQUESTERS  one-hot or zero; bit i: requester i granted this cycle.
REQ-010 rf_write_enable_out  output  1  write enable to register file.
REQ-011 rf_write_address_out  output  AW  register file write address.
REQ-012 rf_write_data_out  output  8  register file write data.
REQ-013 grant_id_out  output  IW  index of requester whose write is on rf_* this cycle.
REQ-014 drop_count_out  output  8  saturating count of dropped writes to register 0.

Function
REQ-015 Transfer on requester i = req_valid_in[i] & req_ready_out[i] at a rising edge.
REQ-016 req_ready_out combinational from req_valid_in, priority pointer and lock state; at most one bit set; zero when no valid.
REQ-017 Round-robin: winner = first valid index at or after pointer, wrapping N-1 -> 0.
REQ-018 Pointer = 0 after reset; after transfer by i, pointer = (i+1) mod NUM_REQUESTERS; no transfer, pointer holds.
REQ-019 Latency one cycle: transfer at edge k drives rf_write_enable_out=1, address, data, grant_id_out during cycle k..k+1; register file commits at edge k+1.
REQ-020 Back-to-back: transfers on consecutive edges from any requesters; sustained throughput one write per cycle.
REQ-021 rf_write_enable_out = 0 in any cycle following an edge with no forwarded transfer; rf_write_address_out/rf_write_data_out/grant_id_out hold last values.
REQ-022 Transfer with address 0: accepted (ready asserted, pointer advances), not forwarded (rf_write_enable_out = 0), drop_count_out += 1, saturating at 255.
REQ-023 Requester-side rule: valid, address, data held stable until transfer; arbiter does not check.

Reset
REQ-024 reset_n_in low asynchronously forces: rf_write_enable_out=0, rf_write_address_out=0, rf_write_data_out=0, grant_id_out=0, drop_count_out=0, pointer=0, lock FSM=UNLOCKED.
REQ-025 req_ready_out = 0 while reset_n_in low; transfer coincident with reset assertion is discarded.
REQ-026 First transfer possible at first rising edge with reset_n_in high.

Configuration
REQ-027 Macro REGFILE_ARB_LOCK_EN compiles in burst lock; absent: no req_lock_in port, pure round-robin per REQ-017.
REQ-028 With macro, FSM states UNLOCKED, LOCKED(owner).
REQ-029 UNLOCKED -> LOCKED(i) on transfer by i with req_lock_in[i]=1.
REQ-030 In LOCKED(i) only requester i may be granted; all other ready bits 0.
REQ-031 LOCKED(i) -> UNLOCKED on transfer by i with req_lock_in[i]=0 (final beat), or on edge with req_lock_in[i]=0 and req_valid_in[i]=0; pointer = (i+1) mod N on exit.
REQ-032 Pointer does not advance while LOCKED.

Verification
REQ-033 Reset release, all valid=1, addresses 1..4, data 0xA0..0xA3 -> ready 0001,0010,0100,1000,0001 on successive cycles; rf writes (1,0xA0),(2,0xA1)... one cycle after each grant.
REQ-034 Only requester 2 valid, addr 7, data 0x55 -> ready[2] same cycle; next cycle rf_write_enable_out=1, addr 7, data 0x55, grant_id_out=2; then enable 0.
REQ-035 Requester 1 writes address 0 three times -> rf_write_enable_out stays 0, drop_count_out=3; 300 such writes -> saturates at 255.
REQ-036 reset_n_in pulled low mid-cycle during continuous traffic -> all outputs 0 immediately, no write of in-flight beat; after release grants resume from requester 0.
REQ-037 With REGFILE_ARB_LOCK_EN: requester 3 sends 4 beats, lock=1,1,1,0, others valid -> four consecutive grants to 3, then grant to 0.
REQ-038 With REGFILE_ARB_LOCK_EN: requester 1 locks, then drops valid and lock -> FSM UNLOCKED next edge, requester 2 granted.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Round-robin arbiter that funnels write requests from NUM_REQUESTERS
//   sources into the single write port of an 8-bit register file. A granted
//   write appears on the rf_* outputs one cycle after its transfer edge.
//   Writes to register 0 are accepted but never forwarded; they are tallied
//   in a saturating 8-bit drop counter instead.
//
// Optional feature:
//   Define REGFILE_ARB_LOCK_EN to compile in burst locking. A requester that
//   transfers with its lock bit set keeps exclusive ownership of the port
//   until it sends a beat with lock clear, or idles with valid and lock both
//   low. Without the macro the req_lock_in port does not exist.
//
// Ports:
//   clock_in              sole clock, rising edge
//   reset_n_in            asynchronous active-low reset
//   req_valid_in [N]      per-requester write pending
//   req_address_in [N*AW] packed target register per requester
//   req_data_in [N*8]     packed write data per requester
//   req_lock_in [N]       per-requester burst lock (REGFILE_ARB_LOCK_EN only)
//   req_ready_out [N]     one-hot grant, combinational
//   rf_write_enable_out   register file write enable
//   rf_write_address_out  register file write address
//   rf_write_data_out     register file write data
//   grant_id_out          requester whose write is on rf_* this cycle
//   drop_count_out        saturating count of dropped writes to register 0
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter  int NUM_REQUESTERS      = 4,
  parameter  int NUMBER_OF_REGISTERS = 256,
  localparam int AW                  = $clog2(NUMBER_OF_REGISTERS),
  localparam int IW                  = $clog2(NUM_REQUESTERS)
) (
  input  logic                         clock_in,
  input  logic                         reset_n_in,
  input  logic [NUM_REQUESTERS-1:0]    req_valid_in,
  input  logic [NUM_REQUESTERS*AW-1:0] req_address_in,
  input  logic [NUM_REQUESTERS*8-1:0]  req_data_in,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic [NUM_REQUESTERS-1:0]    req_lock_in,
`endif
  output logic [NUM_REQUESTERS-1:0]    req_ready_out,
  output logic                         rf_write_enable_out,
  output logic [AW-1:0]                rf_write_address_out,
  output logic [7:0]                   rf_write_data_out,
  output logic [IW-1:0]                grant_id_out,
  output logic [7:0]                   drop_count_out
);

  // Index that follows i in round-robin order, wrapping N-1 back to 0.
  function automatic logic [IW-1:0] nextIndex(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQUESTERS - 1) ? '0 : i + 1'b1;
  endfunction

  logic [IW-1:0] pointer_q, pointer_d;
  logic          writeEnable_q, writeEnable_d;
  logic [AW-1:0] writeAddress_q, writeAddress_d;
  logic [7:0]    writeData_q, writeData_d;
  logic [IW-1:0] grantId_q, grantId_d;
  logic [7:0]    dropCount_q, dropCount_d;

`ifdef REGFILE_ARB_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lockState_e;
  lockState_e    lockState_q, lockState_d;
  logic [IW-1:0] lockOwner_q, lockOwner_d;
`endif

  logic                      grantFound;
  logic [IW-1:0]             grantIdx;
  logic [NUM_REQUESTERS-1:0] readyVec;
  logic                      transfer;
  logic [AW-1:0]             grantAddress;
  logic [7:0]                grantData;

  // Grant selection: scan from the pointer upward with wrap-around and take
  // the first valid requester. A held lock overrides the scan so that only
  // the owner can be granted.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (!grantFound &&
          req_valid_in[IW'((int'(pointer_q) + k) % NUM_REQUESTERS)]) begin
        grantFound = 1'b1;
        grantIdx   = IW'((int'(pointer_q) + k) % NUM_REQUESTERS);
      end
    end
`ifdef REGFILE_ARB_LOCK_EN
    if (lockState_q == LOCKED) begin
      grantFound = req_valid_in[lockOwner_q];
      grantIdx   = lockOwner_q;
    end
`endif
    readyVec = '0;
    if (grantFound) begin
      readyVec[grantIdx] = 1'b1;
    end
  end

  // Ready is forced low during reset so a beat coincident with reset
  // assertion is never counted as a transfer.
  assign req_ready_out = reset_n_in ? readyVec : '0;
  assign transfer      = |req_ready_out;
  assign grantAddress  = req_address_in[grantIdx*AW +: AW];
  assign grantData     = req_data_in[grantIdx*8 +: 8];

  // Next-state logic: pointer advance, write forwarding or drop counting,
  // and the lock FSM. Address and data hold when nothing is forwarded.
  always_comb begin
    pointer_d      = pointer_q;
    writeEnable_d  = 1'b0;
    writeAddress_d = writeAddress_q;
    writeData_d    = writeData_q;
    grantId_d      = grantId_q;
    dropCount_d    = dropCount_q;
`ifdef REGFILE_ARB_LOCK_EN
    lockState_d    = lockState_q;
    lockOwner_d    = lockOwner_q;
`endif

    if (transfer) begin
      pointer_d = nextIndex(grantIdx);
      if (grantAddress == '0) begin
        if (dropCount_q != 8'hFF) begin
          dropCount_d = dropCount_q + 8'd1;
        end
      end else begin
        writeEnable_d  = 1'b1;
        writeAddress_d = grantAddress;
        writeData_d    = grantData;
        grantId_d      = grantIdx;
      end
    end

`ifdef REGFILE_ARB_LOCK_EN
    case (lockState_q)
      UNLOCKED: begin
        if (transfer && req_lock_in[grantIdx]) begin
          lockState_d = LOCKED;
          lockOwner_d = grantIdx;
        end
      end
      LOCKED: begin
        // The pointer is frozen while a burst owns the port and jumps past
        // the owner when the burst ends, whether by a final beat or by the
        // owner going idle.
        pointer_d = pointer_q;
        if (!req_lock_in[lockOwner_q] &&
            (transfer || !req_valid_in[lockOwner_q])) begin
          lockState_d = UNLOCKED;
          pointer_d   = nextIndex(lockOwner_q);
        end
      end
      default: lockState_d = UNLOCKED;
    endcase
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      pointer_q      <= '0;
      writeEnable_q  <= 1'b0;
      writeAddress_q <= '0;
      writeData_q    <= '0;
      grantId_q      <= '0;
      dropCount_q    <= '0;
`ifdef REGFILE_ARB_LOCK_EN
      lockState_q    <= UNLOCKED;
      lockOwner_q    <= '0;
`endif
    end else begin
      pointer_q      <= pointer_d;
      writeEnable_q  <= writeEnable_d;
      writeAddress_q <= writeAddress_d;
      writeData_q    <= writeData_d;
      grantId_q      <= grantId_d;
      dropCount_q    <= dropCount_d;
`ifdef REGFILE_ARB_LOCK_EN
      lockState_q    <= lockState_d;
      lockOwner_q    <= lockOwner_d;
`endif
    end
  end

  assign rf_write_enable_out  = writeEnable_q;
  assign rf_write_address_out = writeAddress_q;
  assign rf_write_data_out    = writeData_q;
  assign grant_id_out         = grantId_q;
  assign drop_count_out       = dropCount_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter with the default 4 requesters and
// 256 registers. Lock scenarios are included when REGFILE_ARB_LOCK_EN is
// defined. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that point and again after inputs settle.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int IW = 2;

  logic          clock_in = 1'b0;
  logic          reset_n_in;
  logic [N-1:0]  req_valid_in;
  logic [N*AW-1:0] req_address_in;
  logic [N*8-1:0]  req_data_in;
`ifdef REGFILE_ARB_LOCK_EN
  logic [N-1:0]  req_lock_in;
`endif
  logic [N-1:0]  req_ready_out;
  logic          rf_write_enable_out;
  logic [AW-1:0] rf_write_address_out;
  logic [7:0]    rf_write_data_out;
  logic [IW-1:0] grant_id_out;
  logic [7:0]    drop_count_out;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(
    .NUM_REQUESTERS      (N),
    .NUMBER_OF_REGISTERS (256)
  ) dut (
    .clock_in             (clock_in),
    .reset_n_in           (reset_n_in),
    .req_valid_in         (req_valid_in),
    .req_address_in       (req_address_in),
    .req_data_in          (req_data_in),
`ifdef REGFILE_ARB_LOCK_EN
    .req_lock_in          (req_lock_in),
`endif
    .req_ready_out        (req_ready_out),
    .rf_write_enable_out  (rf_write_enable_out),
    .rf_write_address_out (rf_write_address_out),
    .rf_write_data_out    (rf_write_data_out),
    .grant_id_out         (grant_id_out),
    .drop_count_out       (drop_count_out)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  always #5 clock_in = ~clock_in;

  // Advance past the next rising edge and let registered outputs settle.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Drive requester inputs and let combinational ready settle.
  task automatic applyStimulus(input logic [N-1:0] valid,
                               input logic [N*AW-1:0] address,
                               input logic [N*8-1:0] data);
    req_valid_in   = valid;
    req_address_in = address;
    req_data_in    = data;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check the whole rf_* bundle after an edge that forwarded a write.
  task automatic checkWrite(input string tag, input logic [AW-1:0] address,
                            input logic [7:0] data, input logic [IW-1:0] id);
    checkOutput({tag, "_we"},   32'(rf_write_enable_out), 32'd1);
    checkOutput({tag, "_addr"}, 32'(rf_write_address_out), 32'(address));
    checkOutput({tag, "_data"}, 32'(rf_write_data_out), 32'(data));
    checkOutput({tag, "_gid"},  32'(grant_id_out), 32'(id));
  endtask

  initial begin
    int g;
    reset_n_in = 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
    req_lock_in = '0;
`endif
    // Round-robin sweep with every requester valid.
    applyStimulus(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1},
                  {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    checkOutput("rst_ready", 32'(req_ready_out), 32'd0);
    checkOutput("rst_we",    32'(rf_write_enable_out), 32'd0);
    checkOutput("rst_addr",  32'(rf_write_address_out), 32'd0);
    checkOutput("rst_data",  32'(rf_write_data_out), 32'd0);
    checkOutput("rst_gid",   32'(grant_id_out), 32'd0);
    checkOutput("rst_drop",  32'(drop_count_out), 32'd0);
    repeat (2) @(posedge clock_in);
    @(negedge clock_in);
    reset_n_in = 1'b1;
    #1;
    checkOutput("rr_ready0", 32'(req_ready_out), 32'b0001);
    for (int b = 0; b < 5; b++) begin
      g = b % 4;
      tick();
      checkWrite($sformatf("rr_beat%0d", b), AW'(g + 1), 8'(8'hA0 + g), IW'(g));
      checkOutput($sformatf("rr_ready%0d", b + 1), 32'(req_ready_out),
                  32'(1 << ((g + 1) % 4)));
    end

    // Single requester 2 write, then idle.
    applyStimulus(4'b0100, {8'd4, 8'd7, 8'd2, 8'd1},
                  {8'hA3, 8'h55, 8'hA1, 8'hA0});
    checkOutput("single_ready", 32'(req_ready_out), 32'b0100);
    tick();
    checkWrite("single", 8'd7, 8'h55, 2'd2);
    applyStimulus(4'b0000, {8'd4, 8'd7, 8'd2, 8'd1},
                  {8'hA3, 8'h55, 8'hA1, 8'hA0});
    checkOutput("idle_ready", 32'(req_ready_out), 32'd0);
    tick();
    checkOutput("idle_we",   32'(rf_write_enable_out), 32'd0);
    checkOutput("idle_addr", 32'(rf_write_address_out), 32'd7);
    checkOutput("idle_data", 32'(rf_write_data_out), 32'h55);
    checkOutput("idle_gid",  32'(grant_id_out), 32'd2);

    // Writes to register 0 from requester 1 are dropped and counted.
    applyStimulus(4'b0010, {8'd4, 8'd7, 8'd0, 8'd1},
                  {8'hA3, 8'h55, 8'hA1, 8'hA0});
    checkOutput("drop_ready", 32'(req_ready_out), 32'b0010);
    repeat (3) begin
      tick();
      checkOutput("drop_we", 32'(rf_write_enable_out), 32'd0);
    end
    checkOutput("drop_count3", 32'(drop_count_out), 32'd3);
    checkOutput("drop_addr_hold", 32'(rf_write_address_out), 32'd7);
    checkOutput("drop_gid_hold", 32'(grant_id_out), 32'd2);
    repeat (252) tick();
    checkOutput("drop_count255", 32'(drop_count_out), 32'd255);
    repeat (45) tick();
    checkOutput("drop_sat", 32'(drop_count_out), 32'd255);
    checkOutput("drop_sat_we", 32'(rf_write_enable_out), 32'd0);

    // Pointer is now 2: requesters 3 and 0 valid exercise the wrap.
    applyStimulus(4'b1001, {8'd9, 8'd7, 8'd0, 8'd5},
                  {8'h33, 8'h55, 8'hA1, 8'h11});
    checkOutput("wrap_ready3", 32'(req_ready_out), 32'b1000);
    tick();
    checkWrite("wrap3", 8'd9, 8'h33, 2'd3);
    checkOutput("wrap_ready0", 32'(req_ready_out), 32'b0001);
    tick();
    checkWrite("wrap0", 8'd5, 8'h11, 2'd0);

    // Asynchronous reset in the middle of continuous traffic.
    applyStimulus(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1},
                  {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    checkOutput("mid_ready", 32'(req_ready_out), 32'b0010);
    tick();
    checkWrite("mid1", 8'd2, 8'hA1, 2'd1);
    tick();
    checkWrite("mid2", 8'd3, 8'hA2, 2'd2);
    #2;
    reset_n_in = 1'b0;
    #1;
    checkOutput("arst_ready", 32'(req_ready_out), 32'd0);
    checkOutput("arst_we",    32'(rf_write_enable_out), 32'd0);
    checkOutput("arst_addr",  32'(rf_write_address_out), 32'd0);
    checkOutput("arst_data",  32'(rf_write_data_out), 32'd0);
    checkOutput("arst_gid",   32'(grant_id_out), 32'd0);
    checkOutput("arst_drop",  32'(drop_count_out), 32'd0);
    @(posedge clock_in);
    @(negedge clock_in);
    checkOutput("arst_hold_we", 32'(rf_write_enable_out), 32'd0);
    reset_n_in = 1'b1;
    #1;
    checkOutput("resume_ready", 32'(req_ready_out), 32'b0001);
    tick();
    checkWrite("resume", 8'd1, 8'hA0, 2'd0);

`ifdef REGFILE_ARB_LOCK_EN
    // Requester 3 bursts four beats with lock 1,1,1,0; pointer is 1 here.
    req_lock_in = 4'b1000;
    applyStimulus(4'b1000, {8'd4, 8'd3, 8'd2, 8'd1},
                  {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    checkOutput("lk_ready_b1", 32'(req_ready_out), 32'b1000);
    tick();
    checkWrite("lk_b1", 8'd4, 8'hA3, 2'd3);
    applyStimulus(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1},
                  {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    checkOutput("lk_ready_b2", 32'(req_ready_out), 32'b1000);
    tick();
    checkWrite("lk_b2", 8'd4, 8'hA3, 2'd3);
    checkOutput("lk_ready_b3", 32'(req_ready_out), 32'b1000);
    tick();
    checkWrite("lk_b3", 8'd4, 8'hA3, 2'd3);
    req_lock_in = 4'b0000;
    #1;
    checkOutput("lk_ready_b4", 32'(req_ready_out), 32'b1000);
    tick();
    checkWrite("lk_b4", 8'd4, 8'hA3, 2'd3);
    checkOutput("lk_ready_after", 32'(req_ready_out), 32'b0001);
    tick();
    checkWrite("lk_after", 8'd1, 8'hA0, 2'd0);

    // Requester 1 locks, then drops valid and lock: requester 2 is next.
    req_lock_in = 4'b0010;
    applyStimulus(4'b0010, {8'd4, 8'd3, 8'd2, 8'd1},
                  {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    tick();
    checkWrite("lk1_b1", 8'd2, 8'hA1, 2'd1);
    applyStimulus(4'b0110, {8'd4, 8'd3, 8'd2, 8'd1},
                  {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    checkOutput("lk1_excl", 32'(req_ready_out), 32'b0010);
    req_lock_in = 4'b0000;
    applyStimulus(4'b0100, {8'd4, 8'd3, 8'd2, 8'd1},
                  {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    checkOutput("lk1_idle_ready", 32'(req_ready_out), 32'd0);
    tick();
    checkOutput("lk1_idle_we", 32'(rf_write_enable_out), 32'd0);
    checkOutput("lk1_unlock_ready", 32'(req_ready_out), 32'b0100);
    tick();
    checkWrite("lk1_next", 8'd3, 8'hA2, 2'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
